// File: rtl/fft_src_ctrl_if.sv
// Bundle for the FFT source-side Avalon-ST stream, the result RAM write port and the host result/handshake signals.
interface fft_src_ctrl_if #(
  parameter int AW = 11,
  parameter int DW = 12,
  parameter int MW = 24
);
  logic                 source_valid;
  logic                 source_sop;
  logic                 source_eop;
  logic signed [DW-1:0] source_real;
  logic signed [DW-1:0] source_imag;
  logic signed [5:0]    source_exp;
  logic [1:0]           source_error;
  logic                 source_ready;

  logic                 mag_we;
  logic [AW-1:0]        mag_addr;
  logic [MW-1:0]        mag_data;

  logic                 res_ack;
  logic                 frame_done;
  logic                 frame_err;
  logic [AW-1:0]        peak_bin;
  logic [MW-1:0]        peak_mag;
  logic signed [5:0]    peak_exp;

  // master: FFT core plus host side; slave: the controller
  modport master (
    output source_valid, source_sop, source_eop, source_real, source_imag,
           source_exp, source_error, res_ack,
    input  source_ready, mag_we, mag_addr, mag_data, frame_done, frame_err,
           peak_bin, peak_mag, peak_exp
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_real, source_imag,
           source_exp, source_error, res_ack,
    output source_ready, mag_we, mag_addr, mag_data, frame_done, frame_err,
           peak_bin, peak_mag, peak_exp
  );
endinterface

// File: rtl/fft_src_ctrl.sv
// Receives one FFT output frame, writes |X|^2 per bin to the result RAM, tracks the
// DC-excluded peak bin, and holds the FFT off until the host acknowledges the results.
module fft_src_ctrl #(
  parameter int N       = 2048,
  parameter int AW      = 11,
  parameter int DW      = 12,
  parameter int MW      = 24,
  parameter int PEAK_LO = 1
) (
  input logic             clk,
  input logic             rst_n,
  fft_src_ctrl_if.slave   bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [AW-1:0] LAST_BIN = AW'(N - 1);
  localparam logic [AW-1:0] PEAK_MIN = AW'(PEAK_LO);
  localparam logic [AW-1:0] PEAK_MAX = AW'(N / 2 - 1);

  logic [1:0]           state_reg;
  logic [AW-1:0]        bin_reg;
  logic [1:0]           drain_cnt_reg;
  logic                 frame_done_reg;
  logic                 frame_err_reg;
  logic signed [5:0]    peak_exp_reg;

  logic                 ready;
  logic                 take;
  logic                 restart;
  logic [AW-1:0]        cur_bin;
  logic                 last_bin;
  logic                 to_drain;
  logic                 err_next;

  logic                 s1_vld_reg;
  logic signed [DW-1:0] s1_re_reg;
  logic signed [DW-1:0] s1_im_reg;
  logic [AW-1:0]        s1_bin_reg;
  logic                 s2_vld_reg;
  logic                 s2_ok_reg;
  logic signed [2*DW-1:0] s2_re2_reg;
  logic signed [2*DW-1:0] s2_im2_reg;
  logic [AW-1:0]        s2_bin_reg;
  logic                 s3_vld_reg;
  logic                 s3_ok_reg;
  logic [MW-1:0]        s3_mag_reg;
  logic [AW-1:0]        s3_bin_reg;
  logic                 mag_we_reg;
  logic [AW-1:0]        mag_addr_reg;
  logic [MW-1:0]        mag_data_reg;
  logic [AW-1:0]        peak_bin_reg;
  logic [MW-1:0]        peak_mag_reg;

  assign ready    = (state_reg == IDLE) || (state_reg == RECV);
  // In IDLE only a sop opens a frame; stray samples are accepted and dropped.
  assign take     = bus.source_valid & ready & (bus.source_sop | (state_reg == RECV));
  assign restart  = take & bus.source_sop;
  assign cur_bin  = bus.source_sop ? '0 : bin_reg;
  assign last_bin = (cur_bin == LAST_BIN);
  assign to_drain = bus.source_eop | last_bin;

  always_comb begin
    err_next = frame_err_reg;
    if (bus.source_sop)
      err_next = (state_reg == RECV);
    // eop must coincide exactly with the last bin, and any FFT error taints the frame
    if ((bus.source_error != 2'd0) || (bus.source_eop != last_bin))
      err_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      bin_reg        <= '0;
      drain_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      peak_exp_reg   <= '0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE, RECV: begin
          if (take) begin
            frame_err_reg <= err_next;
            if (bus.source_sop)
              peak_exp_reg <= bus.source_exp;
            if (to_drain) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= '0;
            end else begin
              state_reg <= RECV;
              bin_reg   <= cur_bin + 1'b1;
            end
          end
        end
        DRAIN: begin
          // three idle cycles let the last sample leave the pipeline before results are final
          if (drain_cnt_reg == 2'd2) begin
            state_reg      <= HOLD;
            frame_done_reg <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 2'd1;
          end
        end
        HOLD: begin
          if (bus.res_ack)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The ok flags stop samples of an abandoned partial frame from updating the restarted peak.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_reg   <= 1'b0;
      s1_re_reg    <= '0;
      s1_im_reg    <= '0;
      s1_bin_reg   <= '0;
      s2_vld_reg   <= 1'b0;
      s2_ok_reg    <= 1'b0;
      s2_re2_reg   <= '0;
      s2_im2_reg   <= '0;
      s2_bin_reg   <= '0;
      s3_vld_reg   <= 1'b0;
      s3_ok_reg    <= 1'b0;
      s3_mag_reg   <= '0;
      s3_bin_reg   <= '0;
      mag_we_reg   <= 1'b0;
      mag_addr_reg <= '0;
      mag_data_reg <= '0;
      peak_bin_reg <= '0;
      peak_mag_reg <= '0;
    end else begin
      s1_vld_reg   <= take;
      s1_re_reg    <= bus.source_real;
      s1_im_reg    <= bus.source_imag;
      s1_bin_reg   <= cur_bin;

      s2_vld_reg   <= s1_vld_reg;
      s2_ok_reg    <= ~restart;
      s2_re2_reg   <= (2*DW)'(s1_re_reg) * (2*DW)'(s1_re_reg);
      s2_im2_reg   <= (2*DW)'(s1_im_reg) * (2*DW)'(s1_im_reg);
      s2_bin_reg   <= s1_bin_reg;

      s3_vld_reg   <= s2_vld_reg;
      s3_ok_reg    <= s2_ok_reg & ~restart;
      s3_mag_reg   <= MW'($unsigned(s2_re2_reg)) + MW'($unsigned(s2_im2_reg));
      s3_bin_reg   <= s2_bin_reg;

      mag_we_reg   <= s3_vld_reg;
      mag_addr_reg <= s3_bin_reg;
      mag_data_reg <= s3_mag_reg;

      if (restart) begin
        peak_bin_reg <= '0;
        peak_mag_reg <= '0;
      end else if (s3_vld_reg && s3_ok_reg && (s3_bin_reg >= PEAK_MIN) &&
                   (s3_bin_reg <= PEAK_MAX) && (s3_mag_reg > peak_mag_reg)) begin
        peak_bin_reg <= s3_bin_reg;
        peak_mag_reg <= s3_mag_reg;
      end
    end
  end

  assign bus.source_ready = ready;
  assign bus.mag_we       = mag_we_reg;
  assign bus.mag_addr     = mag_addr_reg;
  assign bus.mag_data     = mag_data_reg;
  assign bus.frame_done   = frame_done_reg;
  assign bus.frame_err    = frame_err_reg;
  assign bus.peak_bin     = peak_bin_reg;
  assign bus.peak_mag     = peak_mag_reg;
  assign bus.peak_exp     = peak_exp_reg;
endmodule

// File: tb/tb_fft_src_ctrl.sv
// Scoreboard bench for fft_src_ctrl: a frame-level model predicts every RAM write and
// the per-frame peak/error results; a monitor compares them as the DUT presents them.
module tb_fft_src_ctrl;
  localparam int N  = 2048;
  localparam int AW = 11;
  localparam int DW = 12;
  localparam int MW = 24;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { bit err; int pbin; int pmag; int pexp; } fr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   first_we_cyc = -1;

  int         re_a [N];
  int         im_a [N];
  logic [1:0] er_a [N];
  wr_t        wq [$];
  fr_t        fq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_src_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) bus ();

  fft_src_ctrl #(.N(N), .AW(AW), .DW(DW), .MW(MW), .PEAK_LO(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic void chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act == exp_v) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
  endfunction

  // Monitor: one write per accepted sample in order, one result record per frame_done.
  always @(negedge clk) begin
    wr_t w;
    fr_t f;
    if (rst_n) begin
      if (bus.mag_we) begin
        chk("write_expected", longint'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("wr_addr", bus.mag_addr, w.addr);
          chk("wr_data", bus.mag_data, w.data);
        end
        if (bus.mag_addr == '0 && first_we_cyc < 0) first_we_cyc = cyc;
      end
      if (bus.frame_done) begin
        chk("done_expected", longint'(fq.size() > 0), 1);
        if (fq.size() > 0) begin
          f = fq.pop_front();
          chk("frame_err", bus.frame_err, f.err);
          chk("peak_bin", bus.peak_bin, f.pbin);
          chk("peak_mag", bus.peak_mag, f.pmag);
          chk("peak_exp", longint'($unsigned(bus.peak_exp)), f.pexp);
        end
      end
    end
  end

  task automatic fill_zero();
    for (int i = 0; i < N; i++) begin re_a[i] = 0; im_a[i] = 0; er_a[i] = 2'd0; end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      re_a[i] = int'($urandom_range(0, 4095)) - 2048;
      im_a[i] = int'($urandom_range(0, 4095)) - 2048;
      er_a[i] = 2'd0;
    end
  endtask

  // Frame-level reference: error flags and argmax over the eligible half spectrum.
  task automatic push_result(input int nsamp, input logic [5:0] ev);
    fr_t f;
    int  m;
    f.err = (nsamp != N); f.pbin = 0; f.pmag = 0; f.pexp = int'(ev);
    for (int i = 0; i < nsamp; i++) begin
      m = re_a[i] * re_a[i] + im_a[i] * im_a[i];
      if (er_a[i] != 2'd0) f.err = 1'b1;
      if (i >= 1 && i < N / 2 && m > f.pmag) begin f.pmag = m; f.pbin = i; end
    end
    fq.push_back(f);
  endtask

  task automatic stray();
    bus.source_valid = 1'b1; bus.source_sop = 1'b0; bus.source_eop = 1'b1;
    bus.source_real = 12'sd777; bus.source_imag = 12'sd5;
    @(posedge clk); #1;
    bus.source_valid = 1'b0;
    @(negedge clk);
    chk("stray_ignored_ready", bus.source_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int nsamp, input bit gaps, input int abort_at, input logic [5:0] ev);
    int  acc_cyc;
    int  guard;
    bit  acc;
    wr_t w;
    acc_cyc = 0;
    for (int i = 0; i < nsamp; i++) begin
      if (gaps && (i % 3 == 2)) begin
        bus.source_valid = 1'b0; bus.source_sop = 1'($urandom); bus.source_eop = 1'($urandom);
        @(posedge clk); #1;
      end
      bus.source_valid = 1'b1;
      bus.source_sop   = (i == 0);
      bus.source_eop   = (i == nsamp - 1);
      bus.source_real  = DW'(re_a[i]);
      bus.source_imag  = DW'(im_a[i]);
      bus.source_exp   = (i == 0) ? ev : 6'($urandom);
      bus.source_error = er_a[i];
      acc = 1'b0; guard = 0;
      while (!acc && guard < 100) begin
        @(negedge clk); acc = bus.source_ready;
        @(posedge clk); #1; guard++;
      end
      if (!acc) begin
        chk("sample_accept_timeout", acc, 1);
        bus.source_valid = 1'b0;
        return;
      end
      w.addr = i; w.data = re_a[i] * re_a[i] + im_a[i] * im_a[i];
      wq.push_back(w);
      if (i == 0) begin
        acc_cyc = cyc; first_we_cyc = -1;
        chk("err_at_sop", bus.frame_err, longint'(er_a[0] != 2'd0));
        chk("exp_at_sop", longint'($unsigned(bus.peak_exp)), int'(ev));
      end
      if (i == abort_at) begin
        #1 rst_n = 1'b0; #1;
        wq.delete();
        chk("rst_ready", bus.source_ready, 1);
        chk("rst_mag_we", bus.mag_we, 0);
        chk("rst_peak_mag", bus.peak_mag, 0);
        bus.source_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
    end
    bus.source_valid = 1'b0;
    bus.res_ack = 1'b1;
    push_result(nsamp, ev);
    @(negedge clk);
    chk("ready_in_drain", bus.source_ready, 0);
    @(posedge clk); #1 bus.res_ack = 1'b0;
    guard = 0;
    while (!bus.frame_done && guard < 20) begin @(negedge clk); guard++; end
    chk("frame_done_seen", bus.frame_done, 1);
    chk("latency", first_we_cyc - acc_cyc, 3);
    repeat (3) @(negedge clk);
    chk("ready_in_hold", bus.source_ready, 0);
    chk("done_single_cycle", bus.frame_done, 0);
    @(posedge clk); #1 bus.res_ack = 1'b1;
    @(negedge clk);
    chk("ready_during_ack", bus.source_ready, 0);
    @(posedge clk); #1 bus.res_ack = 1'b0;
    @(negedge clk);
    chk("ready_after_ack", bus.source_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

  initial begin
    bus.source_valid = 1'b0; bus.source_sop = 1'b0; bus.source_eop = 1'b0;
    bus.source_real = '0; bus.source_imag = '0; bus.source_exp = '0;
    bus.source_error = 2'd0; bus.res_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", bus.source_ready, 1);
    chk("reset_mag_we", bus.mag_we, 0);
    chk("reset_done", bus.frame_done, 0);
    chk("reset_err", bus.frame_err, 0);
    chk("reset_peak_bin", bus.peak_bin, 0);
    chk("reset_peak_mag", bus.peak_mag, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single tone at bin 100
    fill_zero(); re_a[100] = 2047;
    send_frame(N, 1'b0, -1, 6'd5);

    stray();
    fill_random();
    send_frame(N, 1'b0, -1, 6'($urandom));

    // early eop at bin 999
    fill_random();
    send_frame(1000, 1'b0, -1, 6'($urandom));

    // DC largest, equal maxima at 5 and 700, larger value just past the search range
    fill_zero(); re_a[0] = 2047; re_a[5] = 1000; im_a[700] = -1000; re_a[1024] = 2040; re_a[300] = -999;
    send_frame(N, 1'b1, -1, 6'd63);

    // valid gaps plus an FFT error on bin 10
    fill_random(); er_a[10] = 2'd1;
    send_frame(N, 1'b1, -1, 6'($urandom));

    // reset asserted after bin 500, then clean frames
    fill_random();
    send_frame(N, 1'b0, 500, 6'($urandom));
    fill_zero();
    send_frame(N, 1'b0, -1, 6'd33);
    fill_random(); re_a[N/2 - 1] = -2048; im_a[N/2 - 1] = -2048;
    send_frame(N, 1'($urandom), -1, 6'($urandom));

    repeat (10) @(posedge clk);
    chk("writes_all_seen", wq.size(), 0);
    chk("frames_all_seen", fq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
